// File: rtl/load_store_unit.sv
// Load/store initiator for the data port of a word-wide synchronous memory.
// Sub-word stores are handled as read-modify-write; loads are lane-extracted and extended.
module load_store_unit #(
  parameter logic [31:0] ADDR_LIMIT = 32'd16384
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_wen,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_misalign,
  output logic        resp_fault,
  output logic [31:0] mem_addr,
  input  logic [31:0] mem_rdata,
  output logic        mem_wen,
  output logic [31:0] mem_wdata
);

  typedef enum logic [1:0] {IDLE, READ, MERGE, WRITE} state_t;

  state_t      state, state_nxt;
  logic [31:0] addr_q, wdata_q;
  logic [1:0]  size_q;
  logic        wen_q, uns_q;
  logic        accept, misalign, fault;
  logic [31:0] lane, load_data, merged;

  assign req_ready = (state == IDLE);
  assign accept    = req_valid && req_ready;
  assign mem_addr  = {addr_q[31:2], 2'b00};

  assign misalign = (req_size == 2'b11) ||
                    (req_size == 2'b01 && req_addr[0]) ||
                    (req_size == 2'b10 && req_addr[1:0] != 2'b00);
  assign fault    = (req_addr >= ADDR_LIMIT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // mem_wen decodes purely from state so an async reset kills a write in flight
  always_comb begin
    state_nxt = state;
    mem_wen   = 1'b0;
    case (state)
      IDLE: begin
        if (accept && !misalign && !fault) begin
          if (req_wen && req_size == 2'b10) state_nxt = WRITE;
          else                              state_nxt = READ;
        end
      end
      READ:  state_nxt = MERGE;
      MERGE: begin
        mem_wen   = wen_q;
        state_nxt = IDLE;
      end
      WRITE: begin
        mem_wen   = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign lane = mem_rdata >> {addr_q[1:0], 3'b000};

  always_comb begin
    load_data = mem_rdata;
    case (size_q)
      2'b00: load_data = {{24{lane[7] & ~uns_q}}, lane[7:0]};
      2'b01: load_data = {{16{lane[15] & ~uns_q}}, lane[15:0]};
      default: load_data = mem_rdata;
    endcase
  end

  always_comb begin
    merged = mem_rdata;
    if (size_q == 2'b00)      merged[{addr_q[1:0], 3'b000} +: 8]  = wdata_q[7:0];
    else if (size_q == 2'b01) merged[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
  end

  assign mem_wdata = !mem_wen ? 32'd0 : (state == WRITE) ? wdata_q : merged;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q  <= '0;
      wdata_q <= '0;
      size_q  <= '0;
      wen_q   <= 1'b0;
      uns_q   <= 1'b0;
    end else if (accept) begin
      addr_q  <= req_addr;
      wdata_q <= req_wdata;
      size_q  <= req_size;
      wen_q   <= req_wen;
      uns_q   <= req_unsigned;
    end
  end

  // misalign wins over fault when both apply
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      resp_valid    <= 1'b0;
      resp_rdata    <= '0;
      resp_misalign <= 1'b0;
      resp_fault    <= 1'b0;
    end else begin
      resp_valid    <= 1'b0;
      resp_rdata    <= '0;
      resp_misalign <= 1'b0;
      resp_fault    <= 1'b0;
      case (state)
        IDLE: begin
          if (accept && misalign) begin
            resp_valid    <= 1'b1;
            resp_misalign <= 1'b1;
          end else if (accept && fault) begin
            resp_valid <= 1'b1;
            resp_fault <= 1'b1;
          end
        end
        MERGE: begin
          resp_valid <= 1'b1;
          if (!wen_q) resp_rdata <= load_data;
        end
        WRITE: resp_valid <= 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit with a behavioural synchronous memory.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_wen, req_unsigned;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_misalign, resp_fault;
  logic [31:0] resp_rdata, mem_addr, mem_rdata, mem_wdata;
  logic        mem_wen;

  load_store_unit dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_wen(req_wen),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .resp_misalign(resp_misalign), .resp_fault(resp_fault),
    .mem_addr(mem_addr), .mem_rdata(mem_rdata), .mem_wen(mem_wen), .mem_wdata(mem_wdata)
  );

  always #5 clk = ~clk;

  logic [31:0] ram     [4096];
  logic [31:0] ref_mem [4096];
  int          cyc = 0;
  int          wen_count = 0;
  int          vectors = 0;
  int          miscompares = 0;

  always @(posedge clk) begin
    cyc       <= cyc + 1;
    mem_rdata <= ram[mem_addr[13:2]];
    if (mem_wen) begin
      ram[mem_addr[13:2]] <= mem_wdata;
      wen_count           <= wen_count + 1;
    end
  end

  typedef struct {
    logic [31:0] rdata;
    logic        mis;
    logic        flt;
    int          cyc;
    int          wen_total;
    logic [11:0] idx;
    logic [31:0] word;
  } exp_t;

  exp_t sb[$];
  int   exp_wen_total = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s got=%08h exp=%08h @cyc %0d", tag, got, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (!mem_wen) chk("wdata_idle", mem_wdata, 32'd0);
    if (resp_valid) begin
      if (sb.size() == 0) chk("spurious_resp", 32'd1, 32'd0);
      else begin
        exp_t e;
        e = sb.pop_front();
        chk("resp_cycle", cyc, e.cyc);
        chk("resp_rdata", resp_rdata, e.rdata);
        chk("resp_misalign", resp_misalign, e.mis);
        chk("resp_fault", resp_fault, e.flt);
        chk("wen_count", wen_count, e.wen_total);
        chk("mem_word", ram[e.idx], e.word);
      end
    end
  end

  // Reference model: decides latency, response and memory effect at issue time
  function automatic exp_t model(input logic w, input logic [1:0] sz, input logic u,
                                 input logic [31:0] a, input logic [31:0] d, output int lat);
    exp_t        e;
    logic [31:0] word, sh;
    int          bpos;
    e.idx   = a[13:2];
    e.rdata = 0;
    e.mis   = (sz == 2'b11) || (sz == 2'b01 && a[0]) || (sz == 2'b10 && a[1:0] != 0);
    e.flt   = !e.mis && (a >= 32'h4000);
    word    = ref_mem[a[13:2]];
    bpos    = 8 * int'(a[1:0]);
    if (e.mis || e.flt) lat = 1;
    else if (w) begin
      if (sz == 2'b10) begin word = d; lat = 2; end
      else begin
        lat = 3;
        if (sz == 2'b00) word = (word & ~(32'hFF << bpos)) | ({24'd0, d[7:0]} << bpos);
        else             word = (word & ~(32'hFFFF << bpos)) | ({16'd0, d[15:0]} << bpos);
      end
      ref_mem[a[13:2]] = word;
      exp_wen_total++;
    end else begin
      lat = 3;
      sh  = word >> bpos;
      if (sz == 2'b00)      e.rdata = u ? {24'd0, sh[7:0]}  : {{24{sh[7]}}, sh[7:0]};
      else if (sz == 2'b01) e.rdata = u ? {16'd0, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
      else                  e.rdata = word;
    end
    e.word      = word;
    e.wen_total = exp_wen_total;
    return e;
  endfunction

  // Starts and ends at a negedge; hold keeps req_valid high for back-to-back use
  task automatic issue(input logic w, input logic [1:0] sz, input logic u,
                       input logic [31:0] a, input logic [31:0] d, input bit hold = 0);
    int   guard = 0;
    int   lat;
    exp_t e;
    req_valid = 1; req_wen = w; req_size = sz; req_unsigned = u; req_addr = a; req_wdata = d;
    while (!req_ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    if (!req_ready) begin
      chk("accept_timeout", 32'd0, 32'd1);
      req_valid = 0;
      return;
    end
    e     = model(w, sz, u, a, d, lat);
    e.cyc = cyc + lat;
    sb.push_back(e);
    @(negedge clk);
    if (!hold) req_valid = 0;
  endtask

  task automatic drain();
    int guard = 0;
    while (sb.size() != 0 && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    chk("drain", sb.size(), 0);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) begin ram[i] = 0; ref_mem[i] = 0; end
    mem_rdata = 0;
    rst = 1; req_valid = 0; req_wen = 0; req_size = 0; req_unsigned = 0;
    req_addr = 0; req_wdata = 0;
    repeat (3) @(negedge clk);
    chk("rst_ready", req_ready, 1);
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_mem_wen", mem_wen, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_resp_rdata", resp_rdata, 0);
    rst = 0;
    @(negedge clk);

    // word store then load
    issue(1, 2'b10, 0, 32'h100, 32'hDEADBEEF);
    issue(0, 2'b10, 0, 32'h100, 32'h0);
    drain();

    // byte read-modify-write and signed/unsigned byte loads
    issue(1, 2'b10, 0, 32'h100, 32'h11223344);
    issue(1, 2'b00, 0, 32'h101, 32'h000000AB);
    issue(0, 2'b00, 0, 32'h101, 32'h0);
    issue(0, 2'b00, 1, 32'h101, 32'h0);
    drain();

    // halfword read-modify-write
    issue(1, 2'b10, 0, 32'h100, 32'h11223344);
    issue(1, 2'b01, 0, 32'h102, 32'h00008001);
    issue(0, 2'b01, 0, 32'h102, 32'h0);
    issue(0, 2'b01, 1, 32'h102, 32'h0);
    drain();

    // misalign, fault and their boundaries
    issue(0, 2'b10, 0, 32'h103, 32'h0);
    issue(1, 2'b10, 0, 32'h4000, 32'hCAFEF00D);
    issue(1, 2'b01, 0, 32'h4001, 32'h1234);
    issue(0, 2'b11, 0, 32'h200, 32'h0);
    issue(1, 2'b10, 0, 32'h3FFC, 32'h0BADF00D);
    issue(0, 2'b10, 0, 32'h3FFC, 32'h0);
    drain();

    // reset during MERGE of a byte store
    issue(1, 2'b10, 0, 32'h100, 32'h55667788);
    drain();
    req_valid = 1; req_wen = 1; req_size = 2'b00; req_unsigned = 0;
    req_addr = 32'h100; req_wdata = 32'h000000EE;
    @(negedge clk);
    req_valid = 0;
    @(negedge clk);
    chk("merge_wen", mem_wen, 1);
    #1 rst = 1;
    #1;
    chk("abort_wen", mem_wen, 0);
    chk("abort_ready", req_ready, 1);
    chk("abort_resp_valid", resp_valid, 0);
    chk("abort_mem_addr", mem_addr, 0);
    chk("abort_wdata", mem_wdata, 0);
    repeat (2) @(negedge clk);
    rst = 0;
    @(negedge clk);
    chk("abort_word", ram[12'h040], 32'h55667788);
    chk("abort_wen_count", wen_count, exp_wen_total);
    chk("post_rst_ready", req_ready, 1);

    // back-to-back loads with req_valid held
    issue(1, 2'b10, 0, 32'h180, 32'hA5A5_0001);
    drain();
    for (int i = 0; i < 3; i++) issue(0, 2'b10, 0, 32'h180, 32'h0, 1);
    req_valid = 0;
    drain();

    // random traffic in a small window
    for (int i = 0; i < 24; i++) begin
      issue(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
            32'h200 + 32'($urandom_range(0, 31)), $urandom);
    end
    drain();

    chk("sb_empty", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
